alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Single-issue MIPS ALU front end: decodes one instruction, drives the ALU,
// and holds the captured result until the writeback consumer takes it.
module alu_issue (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_we,
  output logic        branch_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_rs_q, alu_rs_d;
  logic [31:0] alu_rt_q, alu_rt_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic        taken_q, taken_d;
  logic        ill_q, ill_d;
  logic        beq_q, beq_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] dec_rs, dec_rt;
  logic [3:0]  dec_op;
  logic [4:0]  dec_sh, dec_rd;
  logic        dec_ill, dec_beq;
  logic        unused_zero;

  assign unused_zero = alu_zero;
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign instr_ready = (state_q == IDLE) && reset_n;

  always_comb begin
    dec_op  = 4'd0;
    dec_rs  = '0;
    dec_rt  = '0;
    dec_sh  = '0;
    dec_rd  = '0;
    dec_ill = 1'b1;
    dec_beq = 1'b0;
    unique case (1'b1)
      opcode == 6'b000000: begin
        case (funct)
          6'b100000: dec_op = 4'd1;
          6'b100010: dec_op = 4'd2;
          6'b100100: dec_op = 4'd3;
          6'b100101: dec_op = 4'd4;
          6'b100111: dec_op = 4'd5;
          6'b101010: dec_op = 4'd6;
          6'b000000: dec_op = 4'd7;
          6'b000010: dec_op = 4'd8;
          6'b000011: dec_op = 4'd9;
          default:   dec_op = 4'd0;
        endcase
        if (dec_op != 4'd0) begin
          dec_ill = 1'b0;
          dec_rs  = rs_data;
          dec_rt  = rt_data;
          dec_rd  = instr[15:11];
          if (dec_op >= 4'd7)
            dec_sh = instr[10:6];
        end
      end
      opcode == 6'b001000: begin
        dec_op  = 4'd1;
        dec_ill = 1'b0;
        dec_rs  = rs_data;
        dec_rt  = {{16{instr[15]}}, instr[15:0]};
        dec_rd  = instr[20:16];
      end
      opcode == 6'b000100: begin
        dec_op  = 4'd2;
        dec_ill = 1'b0;
        dec_beq = 1'b1;
        dec_rs  = rs_data;
        dec_rt  = rt_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    alu_rs_d = alu_rs_q;
    alu_rt_d = alu_rt_q;
    alu_op_d = alu_op_q;
    shamt_d  = shamt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    rd_d     = rd_q;
    we_d     = we_q;
    taken_d  = taken_q;
    ill_d    = ill_q;
    beq_d    = beq_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          alu_rs_d = dec_rs;
          alu_rt_d = dec_rt;
          alu_op_d = dec_op;
          shamt_d  = dec_sh;
          rd_d     = dec_rd;
          we_d     = !dec_ill && !dec_beq && (dec_rd != 5'd0);
          ill_d    = dec_ill;
          beq_d    = dec_beq;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // Illegal ops never trust the ALU output.
        data_d  = ill_q ? '0 : alu_result;
        taken_d = beq_q && (alu_result == '0);
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          valid_d  = 1'b0;
          we_d     = 1'b0;
          taken_d  = 1'b0;
          alu_op_d = 4'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      alu_rs_q <= '0;
      alu_rt_q <= '0;
      alu_op_q <= '0;
      shamt_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      taken_q  <= 1'b0;
      ill_q    <= 1'b0;
      beq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_rs_q <= alu_rs_d;
      alu_rt_q <= alu_rt_d;
      alu_op_q <= alu_op_d;
      shamt_q  <= shamt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      taken_q  <= taken_d;
      ill_q    <= ill_d;
      beq_q    <= beq_d;
    end
  end

  assign alu_rs       = alu_rs_q;
  assign alu_rt       = alu_rt_q;
  assign alu_op       = alu_op_q;
  assign alu_shamt    = shamt_q;
  assign res_valid    = valid_q;
  assign res_data     = data_q;
  assign res_rd       = rd_q;
  assign res_we       = we_q;
  assign branch_taken = taken_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a falling-edge ALU model
// and hand-computed expectations.
module tb_alu_issue;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we;
  logic        branch_taken;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_rs       (alu_rs),
    .alu_rt       (alu_rt),
    .alu_op       (alu_op),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_rd       (res_rd),
    .res_we       (res_we),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    case (alu_op)
      4'd1: alu_result <= alu_rs + alu_rt;
      4'd2: alu_result <= alu_rs - alu_rt;
      4'd3: alu_result <= alu_rs & alu_rt;
      4'd4: alu_result <= alu_rs | alu_rt;
      4'd5: alu_result <= ~(alu_rs | alu_rt);
      4'd6: alu_result <= {31'd0, $signed(alu_rs) < $signed(alu_rt)};
      4'd7: alu_result <= alu_rt << alu_shamt;
      4'd8: alu_result <= alu_rt >> alu_shamt;
      4'd9: alu_result <= $signed(alu_rt) >>> alu_shamt;
      default: alu_result <= 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Wait for ready, present one instruction, return just after accept edge.
  task automatic issue(input logic [31:0] iw, input logic [31:0] rs,
                       input logic [31:0] rt);
    int n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr       = iw;
    rs_data     = rs;
    rt_data     = rt;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("no_valid_in_exec", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic to_n2();
    step();
    step();
    chk("res_valid_n2", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic complete();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("done_valid", {31'd0, res_valid}, 32'd0);
    chk("done_we", {31'd0, res_we}, 32'd0);
    chk("done_op", {28'd0, alu_op}, 32'd0);
    chk("done_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  logic [31:0] hold_data;

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    rs_data     = '0;
    rt_data     = '0;
    res_ready   = 1'b0;
    step();
    step();
    chk("rst_ready_low", {31'd0, instr_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_rs", alu_rs, 32'd0);

    // ADD $3,$1,$2
    issue({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
    chk("add_op", {28'd0, alu_op}, 32'd1);
    chk("add_rs", alu_rs, 32'd5);
    chk("add_rt", alu_rt, 32'd7);
    chk("add_rd", {27'd0, res_rd}, 32'd3);
    chk("add_we", {31'd0, res_we}, 32'd1);
    chk("add_busy", {31'd0, instr_ready}, 32'd0);
    to_n2();
    chk("add_data", res_data, 32'd12);
    complete();

    // BEQ taken
    issue({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234);
    chk("beq_op", {28'd0, alu_op}, 32'd2);
    chk("beq_we", {31'd0, res_we}, 32'd0);
    to_n2();
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    complete();
    chk("beq_taken_clr", {31'd0, branch_taken}, 32'd0);

    // BEQ not taken
    issue({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1235);
    to_n2();
    chk("bne_taken", {31'd0, branch_taken}, 32'd0);
    chk("bne_data", res_data, 32'hFFFF_FFFF);
    complete();

    // ADDI $4,$0,-1
    issue({6'h08, 5'd0, 5'd4, 16'hFFFF}, 32'd0, 32'd99);
    chk("addi_rt", alu_rt, 32'hFFFF_FFFF);
    chk("addi_rd", {27'd0, res_rd}, 32'd4);
    chk("addi_sh", {27'd0, alu_shamt}, 32'd0);
    chk("addi_we", {31'd0, res_we}, 32'd1);
    to_n2();
    chk("addi_data", res_data, 32'hFFFF_FFFF);
    complete();

    // SLL $2,$5,4
    issue({6'd0, 5'd0, 5'd5, 5'd2, 5'd4, 6'h00}, 32'd0, 32'd1);
    chk("sll_op", {28'd0, alu_op}, 32'd7);
    chk("sll_sh", {27'd0, alu_shamt}, 32'd4);
    to_n2();
    chk("sll_data", res_data, 32'd16);
    complete();

    // SUB $6 with consumer stall and a competing request
    issue({6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h22}, 32'd20, 32'd8);
    to_n2();
    chk("sub_data", res_data, 32'd12);
    hold_data   = res_data;
    instr       = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_data", res_data, hold_data);
      chk("stall_rd", {27'd0, res_rd}, 32'd6);
      chk("stall_op", {28'd0, alu_op}, 32'd2);
      chk("stall_ready", {31'd0, instr_ready}, 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready   = 1'b0;
    instr_valid = 1'b0;
    chk("stall_done_valid", {31'd0, res_valid}, 32'd0);
    chk("stall_done_ready", {31'd0, instr_ready}, 32'd1);
    chk("stall_no_accept", {27'd0, res_rd}, 32'd6);
    step();
    chk("stall_still_idle", {31'd0, instr_ready}, 32'd1);

    // Illegal opcode
    issue({6'h3F, 26'h0ABCDEF}, 32'd3, 32'd4);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_op", {28'd0, alu_op}, 32'd0);
    chk("ill_we", {31'd0, res_we}, 32'd0);
    to_n2();
    chk("ill_data", res_data, 32'd0);
    complete();

    // ADD to $0
    issue({6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'd1, 32'd1);
    chk("r0_we", {31'd0, res_we}, 32'd0);
    chk("r0_ill", {31'd0, illegal}, 32'd0);
    to_n2();
    chk("r0_data", res_data, 32'd2);
    complete();

    // Reset while in EXEC
    issue({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
    reset_n = 1'b0;
    step();
    chk("rx_valid", {31'd0, res_valid}, 32'd0);
    chk("rx_op", {28'd0, alu_op}, 32'd0);
    chk("rx_rs", alu_rs, 32'd0);
    chk("rx_rt", alu_rt, 32'd0);
    chk("rx_data", res_data, 32'd0);
    chk("rx_rd", {27'd0, res_rd}, 32'd0);
    chk("rx_we", {31'd0, res_we}, 32'd0);
    chk("rx_ready_low", {31'd0, instr_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rx_ready", {31'd0, instr_ready}, 32'd1);
    step();
    chk("rx_no_pulse", {31'd0, res_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
